traffic_ctrl_multi: RTL and testbench

Parametrised multi-road traffic-light sequencer for the board LED lab designs. It drives one RGB lamp per approach road and serves the roads round-robin, each through GREEN, YELLOW and ALL_RED phases. Phase durations are in seconds-scale ticks from an internal prescaler, and can be reprogrammed at run time through a register-write port. It also has forced ALL_RED, FLASH and HOLD modes, and a countdown display on the 4-bit LED bank.

---
 rtl/traffic_pkg.sv | 58 +++++
 rtl/traffic_ctrl_multi_tick_prescaler.sv | 45 ++++
 rtl/traffic_ctrl_multi.sv | 245 ++++++++++++++++++++++++
 tb/tb_traffic_ctrl_multi.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// traffic_pkg
//   Shared types and constants for the multi-road traffic-light sequencer.
//   phase_t  : sequencer phase as shown on the phase output
//   mode_t   : operating mode as driven on the mode input
//   CFG_SEL_*: duration-register selector codes for cfg_sel
//   LAMP_*   : lamp colours packed as {r,g,b}
//   lamp_colour(): colour of one road's lamp for a given mode/phase
package traffic_pkg;

   typedef enum logic [1:0] {
      GREEN   = 2'b00,
      YELLOW  = 2'b01,
      ALL_RED = 2'b10
   } phase_t;

   typedef enum logic [1:0] {
      RUN       = 2'b00,
      FLASH     = 2'b01,
      ALL_RED_M = 2'b10,
      HOLD      = 2'b11
   } mode_t;

   localparam logic [1:0] CFG_SEL_GREEN  = 2'b00;
   localparam logic [1:0] CFG_SEL_YELLOW = 2'b01;
   localparam logic [1:0] CFG_SEL_RED    = 2'b10;
   localparam logic [1:0] CFG_SEL_RSVD   = 2'b11;

   localparam logic [2:0] LAMP_RED    = 3'b100;
   localparam logic [2:0] LAMP_YELLOW = 3'b110;
   localparam logic [2:0] LAMP_GREEN  = 3'b010;
   localparam logic [2:0] LAMP_OFF    = 3'b000;

   // Colour of a single road's lamp. 'served' is true for the road the
   // sequencer is currently serving. HOLD is resolved by the caller, which
   // simply keeps the previous lamp values.
   function automatic logic [2:0] lamp_colour(input mode_t  md,
                                              input phase_t ph,
                                              input logic   served,
                                              input logic   flash_on);
      logic [2:0] col;
      col = LAMP_RED;
      case (md)
         FLASH: col = flash_on ? LAMP_YELLOW : LAMP_OFF;
         RUN: begin
            if (served) begin
               case (ph)
                  GREEN:   col = LAMP_GREEN;
                  YELLOW:  col = LAMP_YELLOW;
                  default: col = LAMP_RED;
               endcase
            end
         end
         default: col = LAMP_RED;
      endcase
      return col;
   endfunction

endpackage

// File: rtl/traffic_ctrl_multi_tick_prescaler.sv
// tick_prescaler
//   Divides clk down to a one-cycle tick every TICK_DIV cycles.
//   clk  : clock
//   rst  : synchronous active-low reset (count -> 0)
//   clr  : restart the count at 0 (used on mode changes)
//   en   : count enable; when low the count is frozen
//   tick : high for the cycle in which the count equals TICK_DIV-1
module tick_prescaler #(
   parameter int TICK_DIV = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tick
);

   localparam int               CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // A clear suppresses the tick so the first tick after a mode change is a
   // full TICK_DIV cycles away.
   assign tick = en && !clr && (cnt_q == CNT_LAST);

endmodule

// File: rtl/traffic_ctrl_multi.sv
// traffic_ctrl_multi
//   Round-robin traffic-light sequencer for N_ROADS approach roads. Each road
//   is served GREEN -> YELLOW -> ALL_RED, then the next road takes over.
//   Phase durations live in run-time writable registers.
//   clk       : clock
//   rst       : synchronous active-low reset
//   mode      : 00 RUN, 01 FLASH, 10 ALL_RED, 11 HOLD
//   cfg_we    : write strobe for the duration registers
//   cfg_sel   : 00 green, 01 yellow, 10 all-red, 11 ignored
//   cfg_val   : duration value in ticks
//   lamp_r/g/b: per-road lamp drive (yellow = r+g, blue always 0)
//   led       : remaining ticks of the current phase (0 in FLASH/ALL_RED)
//   road_idx  : road currently served
//   phase     : 00 GREEN, 01 YELLOW, 10 ALL_RED
module traffic_ctrl_multi
   import traffic_pkg::*;
#(
   parameter int N_ROADS      = 2,
   parameter int TIME_W       = 4,
   parameter int TICK_DIV     = 125_000_000,
   parameter int T_GREEN_RST  = 5,
   parameter int T_YELLOW_RST = 1,
   parameter int T_RED_RST    = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [1:0]                 mode,
   input  logic                       cfg_we,
   input  logic [1:0]                 cfg_sel,
   input  logic [TIME_W-1:0]          cfg_val,
   output logic [N_ROADS-1:0]         lamp_r,
   output logic [N_ROADS-1:0]         lamp_g,
   output logic [N_ROADS-1:0]         lamp_b,
   output logic [TIME_W-1:0]          led,
   output logic [$clog2(N_ROADS)-1:0] road_idx,
   output logic [1:0]                 phase
);

   localparam int                ROAD_W    = $clog2(N_ROADS);
   localparam logic [ROAD_W-1:0] LAST_ROAD = ROAD_W'(N_ROADS - 1);
   localparam logic [TIME_W-1:0] ONE       = TIME_W'(1);

   // Duration registers
   logic [TIME_W-1:0] t_green_q, t_green_d;
   logic [TIME_W-1:0] t_yellow_q, t_yellow_d;
   logic [TIME_W-1:0] t_red_q, t_red_d;

   // Sequencer state
   phase_t            phase_q, phase_d;
   logic [ROAD_W-1:0] road_q, road_d;
   logic [TIME_W-1:0] cnt_q, cnt_d;
   mode_t             mode_q, mode_d;
   logic              flash_q, flash_d;
   // Set while FLASH/ALL_RED has overridden the lamps; the next return to RUN
   // must go through a safe all-red restart instead of resuming.
   logic              stale_q, stale_d;

   // Registered outputs
   logic [N_ROADS-1:0] lamp_r_q, lamp_r_d;
   logic [N_ROADS-1:0] lamp_g_q, lamp_g_d;
   logic [N_ROADS-1:0] lamp_b_q, lamp_b_d;
   logic [TIME_W-1:0]  led_q, led_d;

   mode_t             mode_in;
   logic              mode_chg;
   logic              tick;
   logic [ROAD_W-1:0] road_next;
   logic [TIME_W-1:0] green_eff;
   logic [N_ROADS-1:0] dec_r, dec_g, dec_b;

   assign mode_in   = mode_t'(mode);
   assign mode_chg  = (mode_in != mode_q);
   assign road_next = (road_q == LAST_ROAD) ? '0 : road_q + 1'b1;
   // A zero green would stall the sequencer, so it is served as one tick.
   assign green_eff = (t_green_q == '0) ? ONE : t_green_q;

   tick_prescaler #(
      .TICK_DIV (TICK_DIV)
   ) u_prescaler (
      .clk  (clk),
      .rst  (rst),
      .clr  (mode_chg),
      .en   (mode_in != HOLD),
      .tick (tick)
   );

   // ---------------------------------------------------------------------
   // Duration register writes. Phase entries below read the _q values, so
   // an entry on the same edge as a write still sees the old duration.
   // ---------------------------------------------------------------------
   always_comb begin
      t_green_d  = t_green_q;
      t_yellow_d = t_yellow_q;
      t_red_d    = t_red_q;
      if (cfg_we) begin
         case (cfg_sel)
            CFG_SEL_GREEN:  t_green_d  = cfg_val;
            CFG_SEL_YELLOW: t_yellow_d = cfg_val;
            CFG_SEL_RED:    t_red_d    = cfg_val;
            CFG_SEL_RSVD:   ;
            default:        ;
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // Sequencer next state
   // ---------------------------------------------------------------------
   always_comb begin
      phase_d = phase_q;
      road_d  = road_q;
      cnt_d   = cnt_q;
      flash_d = flash_q;
      stale_d = stale_q;
      mode_d  = mode_in;

      if (mode_chg) begin
         case (mode_in)
            RUN: begin
               if (stale_q) begin
                  stale_d = 1'b0;
                  if (t_red_q != '0) begin
                     phase_d = ALL_RED;
                     cnt_d   = t_red_q;
                  end else begin
                     phase_d = GREEN;
                     road_d  = road_next;
                     cnt_d   = green_eff;
                  end
               end
            end
            FLASH: begin
               flash_d = 1'b1;
               stale_d = 1'b1;
            end
            ALL_RED_M: stale_d = 1'b1;
            default: ;
         endcase
      end else if (tick) begin
         if (mode_in == FLASH) begin
            flash_d = !flash_q;
         end else if (mode_in == RUN) begin
            if (cnt_q > ONE) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               // Zero-length yellow / all-red phases are skipped outright.
               case (phase_q)
                  GREEN: begin
                     if (t_yellow_q != '0) begin
                        phase_d = YELLOW;
                        cnt_d   = t_yellow_q;
                     end else if (t_red_q != '0) begin
                        phase_d = ALL_RED;
                        cnt_d   = t_red_q;
                     end else begin
                        phase_d = GREEN;
                        road_d  = road_next;
                        cnt_d   = green_eff;
                     end
                  end
                  YELLOW: begin
                     if (t_red_q != '0) begin
                        phase_d = ALL_RED;
                        cnt_d   = t_red_q;
                     end else begin
                        phase_d = GREEN;
                        road_d  = road_next;
                        cnt_d   = green_eff;
                     end
                  end
                  default: begin
                     phase_d = GREEN;
                     road_d  = road_next;
                     cnt_d   = green_eff;
                  end
               endcase
            end
         end
      end
   end

   // ---------------------------------------------------------------------
   // Per-road lamp decode from the next state
   // ---------------------------------------------------------------------
   for (genvar gi = 0; gi < N_ROADS; gi++) begin : g_lamp
      assign {dec_r[gi], dec_g[gi], dec_b[gi]} =
         lamp_colour(mode_d, phase_d, road_d == ROAD_W'(gi), flash_d);
   end

   always_comb begin
      lamp_r_d = dec_r;
      lamp_g_d = dec_g;
      lamp_b_d = dec_b;
      led_d    = (mode_in == RUN) ? cnt_d : '0;
      if (mode_in == HOLD) begin
         lamp_r_d = lamp_r_q;
         lamp_g_d = lamp_g_q;
         lamp_b_d = lamp_b_q;
         led_d    = led_q;
      end
   end

   // ---------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst) begin
         t_green_q  <= TIME_W'(T_GREEN_RST);
         t_yellow_q <= TIME_W'(T_YELLOW_RST);
         t_red_q    <= TIME_W'(T_RED_RST);
         phase_q    <= ALL_RED;
         road_q     <= LAST_ROAD;
         cnt_q      <= TIME_W'(T_RED_RST);
         mode_q     <= RUN;
         flash_q    <= 1'b0;
         stale_q    <= 1'b0;
         lamp_r_q   <= '1;
         lamp_g_q   <= '0;
         lamp_b_q   <= '0;
         led_q      <= TIME_W'(T_RED_RST);
      end else begin
         t_green_q  <= t_green_d;
         t_yellow_q <= t_yellow_d;
         t_red_q    <= t_red_d;
         phase_q    <= phase_d;
         road_q     <= road_d;
         cnt_q      <= cnt_d;
         mode_q     <= mode_d;
         flash_q    <= flash_d;
         stale_q    <= stale_d;
         lamp_r_q   <= lamp_r_d;
         lamp_g_q   <= lamp_g_d;
         lamp_b_q   <= lamp_b_d;
         led_q      <= led_d;
      end
   end

   assign lamp_r   = lamp_r_q;
   assign lamp_g   = lamp_g_q;
   assign lamp_b   = lamp_b_q;
   assign led      = led_q;
   assign road_idx = road_q;
   assign phase    = phase_q;

endmodule

// File: tb/tb_traffic_ctrl_multi.sv
// Testbench for traffic_ctrl_multi (3 roads, tick every cycle).
// A behavioural model pushes the expected outputs of every edge onto a
// scoreboard queue; each cycle pops and compares. Scenario tasks add their
// own hand-derived checks on top.
module tb_traffic_ctrl_multi;

   localparam int N  = 3;
   localparam int TW = 4;
   localparam int TD = 1;
   localparam int RW = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [1:0]    mode = 2'b00;
   logic          cfg_we = 1'b0;
   logic [1:0]    cfg_sel = 2'b00;
   logic [TW-1:0] cfg_val = '0;
   logic [N-1:0]  lamp_r, lamp_g, lamp_b;
   logic [TW-1:0] led;
   logic [RW-1:0] road_idx;
   logic [1:0]    phase;

   always #5 clk = ~clk;

   traffic_ctrl_multi #(
      .N_ROADS      (N),
      .TIME_W       (TW),
      .TICK_DIV     (TD),
      .T_GREEN_RST  (5),
      .T_YELLOW_RST (1),
      .T_RED_RST    (1)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .mode     (mode),
      .cfg_we   (cfg_we),
      .cfg_sel  (cfg_sel),
      .cfg_val  (cfg_val),
      .lamp_r   (lamp_r),
      .lamp_g   (lamp_g),
      .lamp_b   (lamp_b),
      .led      (led),
      .road_idx (road_idx),
      .phase    (phase)
   );

   typedef struct packed {
      logic [N-1:0]  r;
      logic [N-1:0]  g;
      logic [N-1:0]  b;
      logic [TW-1:0] led;
      logic [RW-1:0] road;
      logic [1:0]    ph;
   } exp_t;

   exp_t sb_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   // Reference model state (phase: 0 G, 1 Y, 2 AR; mode: 0 RUN 1 FLASH 2 AR 3 HOLD)
   int   m_ph, m_road, m_cnt, m_mode, m_pre, m_tg, m_ty, m_tr;
   bit   m_flash, m_stale;
   exp_t m_out;

   task automatic model_enter_green();
      m_road = (m_road + 1) % N;
      m_ph   = 0;
      m_cnt  = (m_tg == 0) ? 1 : m_tg;
   endtask

   task automatic model_edge();
      bit chg, tk;
      if (!rst) begin
         m_ph = 2; m_road = N - 1; m_cnt = 1; m_mode = 0; m_pre = 0;
         m_tg = 5; m_ty = 1; m_tr = 1; m_flash = 0; m_stale = 0;
         m_out.r = '1; m_out.g = '0; m_out.b = '0; m_out.led = TW'(1);
      end else begin
         chg = (int'(mode) != m_mode);
         tk  = !chg && (mode != 2'd3) && (m_pre == TD - 1);
         if (chg) m_pre = 0;
         else if (mode != 2'd3) m_pre = (m_pre == TD - 1) ? 0 : m_pre + 1;
         if (chg) begin
            if (mode == 2'd0 && m_stale) begin
               m_stale = 0;
               if (m_tr > 0) begin m_ph = 2; m_cnt = m_tr; end
               else model_enter_green();
            end else if (mode == 2'd1) begin
               m_flash = 1; m_stale = 1;
            end else if (mode == 2'd2) begin
               m_stale = 1;
            end
         end else if (tk && mode == 2'd1) begin
            m_flash = !m_flash;
         end else if (tk && mode == 2'd0) begin
            if (m_cnt > 1) m_cnt = m_cnt - 1;
            else if (m_ph == 0) begin
               if (m_ty > 0) begin m_ph = 1; m_cnt = m_ty; end
               else if (m_tr > 0) begin m_ph = 2; m_cnt = m_tr; end
               else model_enter_green();
            end else if (m_ph == 1) begin
               if (m_tr > 0) begin m_ph = 2; m_cnt = m_tr; end
               else model_enter_green();
            end else model_enter_green();
         end
         if (cfg_we) begin
            case (cfg_sel)
               2'd0: m_tg = int'(cfg_val);
               2'd1: m_ty = int'(cfg_val);
               2'd2: m_tr = int'(cfg_val);
               default: ;
            endcase
         end
         m_mode = int'(mode);
         if (mode != 2'd3) begin
            for (int k = 0; k < N; k++) begin
               m_out.b[k] = 1'b0;
               if (mode == 2'd1) begin
                  m_out.r[k] = m_flash; m_out.g[k] = m_flash;
               end else if (mode == 2'd0 && k == m_road && m_ph == 0) begin
                  m_out.r[k] = 1'b0; m_out.g[k] = 1'b1;
               end else if (mode == 2'd0 && k == m_road && m_ph == 1) begin
                  m_out.r[k] = 1'b1; m_out.g[k] = 1'b1;
               end else begin
                  m_out.r[k] = 1'b1; m_out.g[k] = 1'b0;
               end
            end
            m_out.led = (mode == 2'd0) ? TW'(m_cnt) : '0;
         end
      end
      m_out.road = RW'(m_road);
      m_out.ph   = 2'(m_ph);
      sb_q.push_back(m_out);
   endtask

   // Advance one edge: model pushes its expectation, DUT result is popped
   // and compared one step #1 after the edge.
   task automatic cycle(input string tag);
      exp_t e;
      model_edge();
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      n_tests++;
      if ({lamp_r, lamp_g, lamp_b, led, road_idx, phase} !== e) begin
         n_fail++;
         $display("FAIL sb_%s: got r=%b g=%b b=%b led=%0d road=%0d ph=%0d, expected r=%b g=%b b=%b led=%0d road=%0d ph=%0d",
                  tag, lamp_r, lamp_g, lamp_b, led, road_idx, phase,
                  e.r, e.g, e.b, e.led, e.road, e.ph);
      end else begin
         $display("[TB] %s led=%0d road=%0d ph=%0d r=%b g=%b", tag, led, road_idx, phase, lamp_r, lamp_g);
      end
   endtask

   task automatic test_reset();
      int exp_led[5] = '{5, 4, 3, 2, 1};
      rst = 1'b0; mode = 2'b00;
      cycle("reset");
      cycle("reset");
      n_tests++;
      if (led !== 4'd1 || road_idx !== 2'd2 || phase !== 2'd2 ||
          lamp_r !== 3'b111 || lamp_g !== 3'b000 || lamp_b !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_values: got led=%0d road=%0d ph=%0d r=%b g=%b b=%b, expected 1 2 2 111 000 000",
                  led, road_idx, phase, lamp_r, lamp_g, lamp_b);
      end
      rst = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cycle("first_green");
         n_tests++;
         if (led !== TW'(exp_led[i]) || phase !== 2'd0 || road_idx !== 2'd0 || lamp_g !== 3'b001) begin
            n_fail++;
            $display("FAIL first_green[%0d]: got led=%0d ph=%0d road=%0d g=%b, expected led=%0d ph=0 road=0 g=001",
                     i, led, phase, road_idx, lamp_g, exp_led[i]);
         end
      end
   endtask

   task automatic test_yellow_write();
      int ycnt = 0;
      // Write lands on the same edge as road0's yellow entry: old value used.
      cfg_we = 1'b1; cfg_sel = 2'd1; cfg_val = 4'd3;
      cycle("yellow_wr");
      cfg_we = 1'b0;
      n_tests++;
      if (phase !== 2'd1 || led !== 4'd1 || road_idx !== 2'd0) begin
         n_fail++;
         $display("FAIL yellow_entry_old: got ph=%0d led=%0d road=%0d, expected ph=1 led=1 road=0", phase, led, road_idx);
      end
      for (int i = 0; i < 10; i++) begin
         cycle("yellow_run");
         if (road_idx == 2'd1 && phase == 2'd1) ycnt++;
      end
      n_tests++;
      if (ycnt != 3) begin
         n_fail++;
         $display("FAIL yellow_new_len: got %0d cycles, expected 3", ycnt);
      end
   endtask

   task automatic test_allred_zero();
      int acnt = 0;
      cfg_we = 1'b1; cfg_sel = 2'd2; cfg_val = 4'd0;
      cycle("red0_wr");
      cfg_we = 1'b0;
      for (int i = 0; i < 16; i++) begin
         cycle("red0_run");
         if (phase == 2'd2) acnt++;
      end
      n_tests++;
      if (acnt != 0 || road_idx !== 2'd1 || phase !== 2'd0 || led !== 4'd5) begin
         n_fail++;
         $display("FAIL red_skip: got allred=%0d road=%0d ph=%0d led=%0d, expected 0 1 0 5", acnt, road_idx, phase, led);
      end
   endtask

   task automatic test_green_zero();
      int gcnt = 0;
      cfg_we = 1'b1; cfg_sel = 2'd0; cfg_val = 4'd0;
      cycle("green0_wr");
      cfg_we = 1'b0;
      for (int i = 0; i < 12; i++) begin
         cycle("green0_run");
         if (phase == 2'd0 && road_idx != 2'd1) gcnt++;
      end
      n_tests++;
      if (gcnt != 2) begin
         n_fail++;
         $display("FAIL green_clamp: got %0d green cycles, expected 2", gcnt);
      end
      cfg_we = 1'b1; cfg_sel = 2'd3; cfg_val = 4'd7;
      cycle("rsvd_wr");
      cfg_we = 1'b0;
      gcnt = 0;
      for (int i = 0; i < 8; i++) begin
         cycle("rsvd_run");
         if (phase == 2'd0) gcnt++;
      end
      n_tests++;
      if (gcnt != 2 || road_idx !== 2'd2 || led !== 4'd2) begin
         n_fail++;
         $display("FAIL rsvd_ignored: got greens=%0d road=%0d led=%0d, expected 2 2 2", gcnt, road_idx, led);
      end
   endtask

   task automatic test_hold();
      bit found = 0;
      int exp_led[2] = '{2, 1};
      for (int i = 0; i < 20 && !found; i++) begin
         if (road_idx == 2'd1 && phase == 2'd1 && led == 4'd2) found = 1;
         else cycle("hold_seek");
      end
      n_tests++;
      if (!found) begin
         n_fail++;
         $display("FAIL hold_seek: got road=%0d ph=%0d led=%0d, expected road1 yellow led 2", road_idx, phase, led);
      end
      mode = 2'd3;
      for (int i = 0; i < 10; i++) begin
         cycle("hold");
         n_tests++;
         if (led !== 4'd2 || phase !== 2'd1 || road_idx !== 2'd1 ||
             lamp_r !== 3'b111 || lamp_g !== 3'b010 || lamp_b !== 3'b000) begin
            n_fail++;
            $display("FAIL hold_frozen[%0d]: got led=%0d ph=%0d road=%0d r=%b g=%b, expected 2 1 1 111 010",
                     i, led, phase, road_idx, lamp_r, lamp_g);
         end
      end
      mode = 2'd0;
      for (int i = 0; i < 2; i++) begin
         cycle("hold_resume");
         n_tests++;
         if (led !== TW'(exp_led[i]) || phase !== 2'd1 || road_idx !== 2'd1) begin
            n_fail++;
            $display("FAIL hold_resume[%0d]: got led=%0d ph=%0d road=%0d, expected led=%0d ph=1 road=1",
                     i, led, phase, road_idx, exp_led[i]);
         end
      end
   endtask

   task automatic test_flash();
      logic [N-1:0] want;
      cfg_we = 1'b1; cfg_sel = 2'd2; cfg_val = 4'd2;
      cycle("flash_cfg");
      cfg_we = 1'b0;
      mode = 2'd1;
      for (int i = 0; i < 4; i++) begin
         cycle("flash");
         want = (i % 2 == 0) ? 3'b111 : 3'b000;
         n_tests++;
         if (lamp_r !== want || lamp_g !== want || lamp_b !== 3'b000 || led !== 4'd0) begin
            n_fail++;
            $display("FAIL flash[%0d]: got r=%b g=%b b=%b led=%0d, expected r=g=%b b=000 led=0",
                     i, lamp_r, lamp_g, lamp_b, led, want);
         end
      end
      mode = 2'd0;
      cycle("flash_exit");
      n_tests++;
      if (phase !== 2'd2 || road_idx !== 2'd2 || led !== 4'd2 || lamp_r !== 3'b111 || lamp_g !== 3'b000) begin
         n_fail++;
         $display("FAIL flash_restart: got ph=%0d road=%0d led=%0d, expected ph=2 road=2 led=2", phase, road_idx, led);
      end
      cycle("flash_exit");
      cycle("flash_exit");
      n_tests++;
      if (phase !== 2'd0 || road_idx !== 2'd0 || led !== 4'd1) begin
         n_fail++;
         $display("FAIL flash_next_green: got ph=%0d road=%0d led=%0d, expected ph=0 road=0 led=1", phase, road_idx, led);
      end
   endtask

   task automatic test_all_red_mode();
      mode = 2'd2;
      cfg_we = 1'b1; cfg_sel = 2'd2; cfg_val = 4'd0;
      for (int i = 0; i < 3; i++) begin
         cycle("allred_mode");
         cfg_we = 1'b0;
         n_tests++;
         if (lamp_r !== 3'b111 || lamp_g !== 3'b000 || led !== 4'd0) begin
            n_fail++;
            $display("FAIL allred_mode[%0d]: got r=%b g=%b led=%0d, expected 111 000 0", i, lamp_r, lamp_g, led);
         end
      end
      mode = 2'd0;
      cycle("allred_exit");
      n_tests++;
      if (phase !== 2'd0 || road_idx !== 2'd1 || led !== 4'd1) begin
         n_fail++;
         $display("FAIL allred_zero_restart: got ph=%0d road=%0d led=%0d, expected ph=0 road=1 led=1", phase, road_idx, led);
      end
   endtask

   task automatic test_reset_mid();
      rst = 1'b0;
      cfg_we = 1'b1; cfg_sel = 2'd0; cfg_val = 4'd9;
      cycle("rst_mid");
      n_tests++;
      if (led !== 4'd1 || road_idx !== 2'd2 || phase !== 2'd2 || lamp_r !== 3'b111 || lamp_g !== 3'b000) begin
         n_fail++;
         $display("FAIL rst_mid_values: got led=%0d road=%0d ph=%0d r=%b g=%b, expected 1 2 2 111 000",
                  led, road_idx, phase, lamp_r, lamp_g);
      end
      rst = 1'b1; cfg_we = 1'b0;
      cycle("rst_after");
      n_tests++;
      if (led !== 4'd5 || road_idx !== 2'd0 || phase !== 2'd0) begin
         n_fail++;
         $display("FAIL rst_write_dropped: got led=%0d road=%0d ph=%0d, expected 5 0 0", led, road_idx, phase);
      end
      cycle("rst_after");
      cycle("rst_after");
   endtask

   initial begin
      test_reset();
      test_yellow_write();
      test_allred_zero();
      test_green_zero();
      test_hold();
      test_flash();
      test_all_red_mode();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
